spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave with synchronized pin sampling and single-byte TX staging
//
// Purpose:
//   The SPI pins are sampled in the sys_clk_i domain. SCLK must stay at least
//   4 sys_clk_i cycles in each half-period. CPOL and CPHA come from SPI_MODE.
//   Data is shifted MSB first in both directions. Frames may carry any number
//   of back-to-back bytes.
//
// Ports:
//   sys_clk_i   system clock; every flop uses its rising edge
//   rstn_i      asynchronous active-low reset
//   tx_dv_i     strobe that offers tx_byte_i to the pending register
//   tx_byte_i   byte to be shifted out on MISO
//   tx_ready_o  high while the pending register is empty
//   rx_dv_o     one-cycle pulse when rx_byte_o is updated
//   rx_byte_o   last complete byte received on MOSI
//   sclk_i      SPI clock from the master (asynchronous)
//   mosi_i      serial data from the master
//   cs_i        active-low chip select
//   miso_o      serial data to the master
//   miso_oe_o   MISO output enable, high only inside an active frame

module spi_slave #(
  parameter logic [1:0] SPI_MODE = 2'd0
) (
  input  logic       sys_clk_i,
  input  logic       rstn_i,
  input  logic       tx_dv_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_ready_o,
  output logic       rx_dv_o,
  output logic [7:0] rx_byte_o,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_i,
  output logic       miso_o,
  output logic       miso_oe_o
);

  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Two-flop synchronizers, plus one more flop per line for edge detection.
  // MOSI goes through the same depth as SCLK. A detected sampling edge
  // therefore sees the MOSI value that was on the pin at that SCLK edge.
  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_d;
  logic       cs_d;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_sync <= {2{CPOL}};
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_i};
      cs_sync   <= {cs_sync[0], cs_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // The leading edge moves SCLK away from its idle level.
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] pending;
  logic [7:0] load_byte;

  // tx_ready_o doubles as the "pending empty" flag.
  // An empty register sends 0x00.
  assign load_byte = tx_ready_o ? 8'h00 : pending;

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      rx_byte_o  <= 8'h00;
      rx_dv_o    <= 1'b0;
      tx_shift   <= 8'h00;
      pending    <= 8'h00;
      tx_ready_o <= 1'b1;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
    end else begin
      rx_dv_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= ACTIVE;
            bit_cnt    <= 3'd0;
            miso_oe_o  <= 1'b1;
            tx_ready_o <= 1'b1;
            if (CPHA) begin
              // The MSB goes out on the first leading edge.
              tx_shift <= load_byte;
            end else begin
              // With CPHA=0 the master samples on the first leading edge.
              // The MSB must therefore be on the pin before any SCLK activity.
              miso_o   <= load_byte[7];
              tx_shift <= {load_byte[6:0], 1'b0};
            end
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            // Drop any partial byte. The pending byte survives for the next frame.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte_o  <= {rx_shift, mosi_s};
              rx_dv_o    <= 1'b1;
              // Byte boundary: the next shift edge sends this byte's MSB.
              tx_shift   <= load_byte;
              tx_ready_o <= 1'b1;
            end
          end else if (shift_edge) begin
            miso_o   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      endcase

      // An accept in the same cycle as a load point lands in pending.
      // The load above already used the old (empty) value.
      if (tx_dv_i && tx_ready_o) begin
        pending    <= tx_byte_i;
        tx_ready_o <= 1'b0;
      end
    end
  end

endmodule
